// File: rtl/qpsk_phase_slicer.sv
// QPSK phase-ambiguity resolver and hard slicer feeding the Fano decoder.
// A 3-stage pipeline (capture, rotate, slice) is flushed on every phase step or LLR reset.
module qpsk_phase_slicer #(
  parameter int unsigned IQ_DATA_WIDTH = 10,
  parameter int unsigned NUM_PHASES    = 4
) (
  input  logic                     CLK,
  input  logic                     nRESET,
  input  logic                     i_vld,
  input  logic [IQ_DATA_WIDTH-1:0] i_i,
  input  logic [IQ_DATA_WIDTH-1:0] i_q,
  input  logic                     i_shift_phs,
  input  logic                     i_llr_reset,
  output logic                     o_vld,
  output logic [1:0]               o_data,
  output logic [2:0]               o_phase,
  output logic                     o_last_phase_stb
);

  localparam int unsigned W = IQ_DATA_WIDTH;
  localparam logic [2:0] LastPhase = 3'(NUM_PHASES - 1);
  localparam bit UseConj = (NUM_PHASES == 8);

  typedef logic signed [W-1:0] iq_t;

  // Saturating negation: the most negative code maps to the most positive one.
  function automatic iq_t sat_neg(input iq_t x);
    iq_t min_val;
    min_val = {1'b1, {(W-1){1'b0}}};
    if (x == min_val) begin
      return {1'b0, {(W-1){1'b1}}};
    end
    return -x;
  endfunction

  logic       flush;
  logic       phase_last;
  logic [2:0] phase_q, phase_d;

  logic s1_vld_q, s2_vld_q;
  iq_t  s1_i_q, s1_q_q;
  iq_t  s2_i_q, s2_q_q;
  iq_t  conj_q, rot_i, rot_q;

  assign flush      = i_shift_phs | i_llr_reset;
  assign phase_last = (phase_q == LastPhase);
  assign phase_d    = phase_last ? 3'd0 : phase_q + 3'd1;
  assign o_phase    = phase_q;

  always_comb begin
    rot_i  = s1_i_q;
    rot_q  = s1_q_q;
    conj_q = (UseConj && phase_q[2]) ? sat_neg(s1_q_q) : s1_q_q;
    unique case (phase_q[1:0])
      2'd0: begin rot_i = s1_i_q;          rot_q = conj_q;          end
      2'd1: begin rot_i = sat_neg(conj_q); rot_q = s1_i_q;          end
      2'd2: begin rot_i = sat_neg(s1_i_q); rot_q = sat_neg(conj_q); end
      2'd3: begin rot_i = conj_q;          rot_q = sat_neg(s1_i_q); end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      phase_q          <= 3'd0;
      s1_vld_q         <= 1'b0;
      s1_i_q           <= '0;
      s1_q_q           <= '0;
      s2_vld_q         <= 1'b0;
      s2_i_q           <= '0;
      s2_q_q           <= '0;
      o_vld            <= 1'b0;
      o_data           <= 2'b00;
      o_last_phase_stb <= 1'b0;
    end else begin
      s1_vld_q <= i_vld & ~flush;
      s1_i_q   <= i_i;
      s1_q_q   <= i_q;
      s2_vld_q <= s1_vld_q & ~flush;
      s2_i_q   <= rot_i;
      s2_q_q   <= rot_q;
      o_vld    <= s2_vld_q & ~flush;
      // o_data only moves with a delivered symbol so it holds through gaps.
      if (s2_vld_q && !flush) begin
        o_data <= {s2_i_q[W-1], s2_q_q[W-1]};
      end
      if (i_shift_phs) begin
        phase_q <= phase_d;
      end
      o_last_phase_stb <= i_shift_phs & phase_last;
    end
  end

endmodule

// File: tb/tb_qpsk_phase_slicer.sv
// Directed bench for qpsk_phase_slicer: a 4-phase and an 8-phase instance share one stimulus.
module tb_qpsk_phase_slicer;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       i_vld;
  logic [9:0] i_i, i_q;
  logic       i_shift_phs, i_llr_reset;

  logic       vld4, vld8, stb4, stb8;
  logic [1:0] data4, data8;
  logic [2:0] phase4, phase8;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  qpsk_phase_slicer #(.IQ_DATA_WIDTH(10), .NUM_PHASES(4)) dut4 (
    .CLK(CLK), .nRESET(nRESET), .i_vld(i_vld), .i_i(i_i), .i_q(i_q),
    .i_shift_phs(i_shift_phs), .i_llr_reset(i_llr_reset),
    .o_vld(vld4), .o_data(data4), .o_phase(phase4), .o_last_phase_stb(stb4)
  );

  qpsk_phase_slicer #(.IQ_DATA_WIDTH(10), .NUM_PHASES(8)) dut8 (
    .CLK(CLK), .nRESET(nRESET), .i_vld(i_vld), .i_i(i_i), .i_q(i_q),
    .i_shift_phs(i_shift_phs), .i_llr_reset(i_llr_reset),
    .o_vld(vld8), .o_data(data8), .o_phase(phase8), .o_last_phase_stb(stb8)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] ii, input logic [9:0] qq);
    i_vld = v;
    i_i   = ii;
    i_q   = qq;
  endtask

  localparam logic [9:0] P100 = 10'd100;
  localparam logic [9:0] N100 = 10'h39C;  // -100
  localparam logic [9:0] N512 = 10'h200;  // -512

  logic [2:0] exp_ph4 [4] = '{3'd2, 3'd3, 3'd0, 3'd1};
  logic [2:0] exp_ph8 [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic       exp_stb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] exp_d4  [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
  logic [1:0] exp_d8  [4] = '{2'b11, 2'b01, 2'b01, 2'b00};

  initial begin
    nRESET = 1'b0;
    i_shift_phs = 1'b0;
    i_llr_reset = 1'b0;
    drive(1'b1, P100, N100);
    tick();
    tick();
    chk("reset_vld", {7'd0, vld4}, 8'd0);
    chk("reset_data", {6'd0, data4}, 8'd0);
    chk("reset_phase", {5'd0, phase4}, 8'd0);
    chk("reset_stb", {7'd0, stb4}, 8'd0);

    // First sample: latency 3
    nRESET = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    drive(1'b1, P100, P100);
    tick();
    drive(1'b0, '0, '0);
    chk("lat_n1_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("lat_n2_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("lat_n3_vld", {7'd0, vld4}, 8'd1);
    chk("lat_n3_data", {6'd0, data4}, 8'd0);
    chk("lat_n3_phase", {5'd0, phase4}, 8'd0);
    tick();
    chk("lat_n4_vld", {7'd0, vld4}, 8'd0);

    // Phase-0 stream of four quadrants
    drive(1'b1, N100, P100); tick();
    drive(1'b1, P100, N100); tick();
    drive(1'b1, N100, N100); tick();
    chk("s0_vld", {7'd0, vld4}, 8'd1);
    chk("s0_data", {6'd0, data4}, 8'h2);
    drive(1'b1, '0, '0); tick();
    drive(1'b0, '0, '0);
    chk("s1_vld", {7'd0, vld4}, 8'd1);
    chk("s1_data", {6'd0, data4}, 8'h1);
    tick();
    chk("s2_vld", {7'd0, vld4}, 8'd1);
    chk("s2_data", {6'd0, data4}, 8'h3);
    tick();
    chk("s3_vld", {7'd0, vld4}, 8'd1);
    chk("s3_data", {6'd0, data4}, 8'h0);
    tick();
    chk("s4_vld", {7'd0, vld4}, 8'd0);

    // Shift during a continuous (100,100) stream
    drive(1'b1, P100, P100);
    for (int k = 0; k < 4; k++) tick();
    chk("pre_shift_vld", {7'd0, vld4}, 8'd1);
    i_shift_phs = 1'b1;
    tick();
    i_shift_phs = 1'b0;
    chk("sh_t1_vld", {7'd0, vld4}, 8'd0);
    chk("sh_t1_hold", {6'd0, data4}, 8'h0);
    chk("sh_t1_phase", {5'd0, phase4}, 8'd1);
    tick();
    chk("sh_t2_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("sh_t3_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("sh_t4_vld", {7'd0, vld4}, 8'd1);
    chk("sh_t4_data", {6'd0, data4}, 8'h2);

    // Saturation at phase 1: (-512,-512) -> (511,-512)
    drive(1'b1, N512, N512);
    tick();
    drive(1'b0, '0, '0);
    tick();
    tick();
    chk("sat_vld", {7'd0, vld4}, 8'd1);
    chk("sat_data4", {6'd0, data4}, 8'h1);
    chk("sat_data8", {6'd0, data8}, 8'h1);
    for (int k = 0; k < 3; k++) tick();

    // Four strobes spaced 10 cycles, one probe sample after each
    for (int j = 0; j < 4; j++) begin
      i_shift_phs = 1'b1;
      tick();
      i_shift_phs = 1'b0;
      chk($sformatf("step%0d_phase4", j), {5'd0, phase4}, {5'd0, exp_ph4[j]});
      chk($sformatf("step%0d_phase8", j), {5'd0, phase8}, {5'd0, exp_ph8[j]});
      chk($sformatf("step%0d_stb4", j), {7'd0, stb4}, {7'd0, exp_stb[j]});
      chk($sformatf("step%0d_stb8", j), {7'd0, stb8}, 8'd0);
      drive(1'b1, P100, P100);
      tick();
      drive(1'b0, '0, '0);
      chk($sformatf("step%0d_stb4_off", j), {7'd0, stb4}, 8'd0);
      tick();
      tick();
      chk($sformatf("step%0d_vld", j), {7'd0, vld4}, 8'd1);
      chk($sformatf("step%0d_data4", j), {6'd0, data4}, {6'd0, exp_d4[j]});
      chk($sformatf("step%0d_data8", j), {6'd0, data8}, {6'd0, exp_d8[j]});
      for (int k = 0; k < 6; k++) tick();
    end

    // Simultaneous shift + LLR reset mid-stream (phase 1 -> 2)
    drive(1'b1, P100, P100);
    for (int k = 0; k < 4; k++) tick();
    chk("both_pre_data", {6'd0, data4}, 8'h2);
    i_shift_phs = 1'b1;
    i_llr_reset = 1'b1;
    tick();
    i_shift_phs = 1'b0;
    i_llr_reset = 1'b0;
    chk("both_t1_vld", {7'd0, vld4}, 8'd0);
    chk("both_t1_hold", {6'd0, data4}, 8'h2);
    chk("both_t1_phase", {5'd0, phase4}, 8'd2);
    tick();
    chk("both_t2_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("both_t3_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("both_t4_vld", {7'd0, vld4}, 8'd1);
    chk("both_t4_data", {6'd0, data4}, 8'h3);

    // LLR reset alone: flush, phase unchanged
    i_llr_reset = 1'b1;
    tick();
    i_llr_reset = 1'b0;
    chk("llr_t1_vld", {7'd0, vld4}, 8'd0);
    chk("llr_t1_phase", {5'd0, phase4}, 8'd2);
    tick();
    tick();
    chk("llr_t3_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("llr_t4_vld", {7'd0, vld4}, 8'd1);
    chk("llr_t4_data", {6'd0, data4}, 8'h3);

    // Reset mid-stream
    nRESET = 1'b0;
    tick();
    chk("mid_rst_vld", {7'd0, vld4}, 8'd0);
    chk("mid_rst_phase", {5'd0, phase4}, 8'd0);
    chk("mid_rst_phase8", {5'd0, phase8}, 8'd0);
    chk("mid_rst_data", {6'd0, data4}, 8'd0);
    nRESET = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    tick();
    tick();
    chk("post_rst_vld", {7'd0, vld4}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_phase_slicer.md
Name: qpsk_phase_slicer

Overview:
- Front-end stage that feeds fano_decoder.
- Takes signed I/Q QPSK samples from the demodulator and resolves the phase ambiguity with a phase-index register. The index steps once per o_shift_phs strobe from the decoder.
- Hard-slices each rotated sample into the 2-bit symbol consumed on the decoder's i_data/i_vld.
- Generates i_last_phase_stb for the decoder, and flushes in-flight symbols on every phase change or LLR reset.

Parameters:
- IQ_DATA_WIDTH, 10, width of signed I and Q input samples.
- NUM_PHASES, 4, number of ambiguity states: 4 = rotations only; 8 = rotations plus conjugation. Any other value is illegal.

Ports:
- CLK  input  1  clock.
- nRESET  input  1  reset, synchronous, active-low.
- i_vld  input  1  input sample valid.
- i_i  input  IQ_DATA_WIDTH  signed in-phase sample.
- i_q  input  IQ_DATA_WIDTH  signed quadrature sample.
- i_shift_phs  input  1  one-cycle strobe: advance phase index (driven from decoder o_shift_phs).
- i_llr_reset  input  1  one-cycle strobe: flush pipeline (driven from decoder o_llr_reset).
- o_vld  output  1  symbol valid (to decoder i_vld).
- o_data  output  2  hard symbol; [1] = I decision, [0] = Q decision.
- o_phase  output  3  current phase index; bit 2 is always 0 when NUM_PHASES=4.
- o_last_phase_stb  output  1  one-cycle pulse when the index wraps back to 0.

Behaviour:
- Reset (nRESET=0 at a CLK edge): all outputs 0, phase index 0, all pipeline valid bits 0. Reset overrides every other input. Reset mid-stream discards all in-flight samples.
- Pipeline has 3 register stages:
  - S1 captures i_i/i_q/i_vld.
  - S2 applies the rotation using the current phase index.
  - S3 slices and drives o_data/o_vld.
- Latency: a sample with i_vld=1 in cycle n appears with o_vld=1 in cycle n+3, unless flushed.
- o_vld is high only in cycles carrying a new symbol. No backpressure; the downstream decoder always accepts.
- o_data holds its last value while o_vld=0.
- Phase index p:
  - p[1:0] = rotation k.
  - p[2] = conjugate, used only when NUM_PHASES=8.
- Rotation: first conjugate if p[2] (Q := -Q), then rotate by k*90 degrees:
  - k=0: (I,Q).
  - k=1: (-Q,I).
  - k=2: (-I,-Q).
  - k=3: (Q,-I).
- Negation saturates: -2^(W-1) becomes 2^(W-1)-1. No width growth.
- Slicing: decision bit = 1 if the component is negative, 0 if the component is >= 0 (zero maps to 0).
- Phase stepping: i_shift_phs=1 in cycle t advances p at the end of t: p := (p+1) mod NUM_PHASES.
  - New p is visible on o_phase and used by S2 from cycle t+1.
- Wrap: if p = NUM_PHASES-1 when the strobe occurs, p := 0 and o_last_phase_stb=1 in cycle t+1 only. Otherwise o_last_phase_stb=0.
- Flush: i_shift_phs=1 or i_llr_reset=1 in cycle t clears the S1, S2 and S3 valid bits at the end of t. The sample presented in cycle t is also dropped.
  - Result: o_vld=0 in cycles t+1..t+3.
  - The first sample accepted at cycle t+1 exits at t+4 and uses the new phase.
  - No symbol is ever sliced with mixed old/new phase.
- Simultaneous i_shift_phs and i_llr_reset: a single flush, and the phase still advances.
- i_llr_reset alone: flush only; p unchanged.
- Back-to-back shift strobes: each advances p by one; the flush window restarts from the last strobe.
- Strobes with i_vld=0 behave identically (phase update still occurs).

Test Plan:
- Reset then i_vld=1, I=100, Q=100 in cycle n -> o_vld=1 at n+3, o_data=2'b00, o_phase=0; all outputs 0 during reset.
- Phase 0 stream (I,Q) = (-100,100), (100,-100), (-100,-100), (0,0) on consecutive cycles -> o_data = 10, 01, 11, 00 on consecutive cycles, no gaps.
- i_shift_phs at cycle t during a continuous stream -> o_vld=0 for t+1..t+3; o_phase=1 from t+1; then (100,100) maps to (-100,100), giving o_data=10.
- NUM_PHASES=4, four strobes spaced 10 cycles apart -> o_phase 1,2,3,0; o_last_phase_stb high exactly one cycle, after the 4th strobe.
- Phase 1 with I=Q=-512 -> rotated (511,-512), o_data=01 (saturation check). NUM_PHASES=8, phase 4, (100,100) -> o_data=01 (conjugate).
- i_llr_reset and i_shift_phs in the same cycle mid-stream -> single 3-cycle o_vld gap, phase +1. nRESET low mid-stream -> o_vld=0 next cycle, o_phase=0.
